// File: rtl/encoder64to6_scan.sv
// encoder64to6_scan: serializes a captured 64-bit multi-hot vector into a stream of 6-bit set-bit indices
module encoder64to6_scan #(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [63:0] in_vec,
  output logic [5:0]  out_idx,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        done,
  output logic [6:0]  remaining
);
  typedef enum logic {IDLE, EMIT} state_t;
  state_t      state, state_n;
  logic [63:0] pending, pending_n, cleared, src;
  logic [5:0]  idx_n, first;
  logic        valid_n, done_n;
  logic [6:0]  rem_n;
  function automatic logic [2:0] sel8(input logic [7:0] v);
    logic [2:0] r;
    r = '0;
    for (int i = 0; i < 8; i++)
      if (v[MSB_FIRST ? i : 7 - i]) r = MSB_FIRST ? 3'(i) : 3'(7 - i);
    return r;
  endfunction
  // group of 8 chosen first, then the bit within that group
  function automatic logic [5:0] pick(input logic [63:0] v);
    logic [7:0] g;
    logic [2:0] gs;
    for (int i = 0; i < 8; i++) g[i] = |v[8*i +: 8];
    gs = sel8(g);
    return {gs, sel8(v[8*gs +: 8])};
  endfunction
  assign cleared = pending & ~(64'd1 << out_idx);
  assign src     = (state == IDLE) ? in_vec : cleared;
  assign first   = pick(src);
  assign busy    = (state == EMIT);
  always_comb begin
    state_n   = state;
    pending_n = pending;
    idx_n     = out_idx;
    valid_n   = out_valid;
    rem_n     = remaining;
    done_n    = 1'b0;
    if (state == IDLE) begin
      if (load) begin
        pending_n = in_vec;
        if (|in_vec) begin
          state_n = EMIT;
          valid_n = 1'b1;
          idx_n   = first;
          rem_n   = 7'($countones(in_vec));
        end else done_n = 1'b1;
      end
    end else if (out_ready) begin
      pending_n = cleared;
      rem_n     = remaining - 7'd1;
      if (|cleared) idx_n = first;
      else begin
        state_n = IDLE;
        valid_n = 1'b0;
        done_n  = 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      pending   <= '0;
      out_idx   <= '0;
      out_valid <= 1'b0;
      done      <= 1'b0;
      remaining <= '0;
    end else begin
      state     <= state_n;
      pending   <= pending_n;
      out_idx   <= idx_n;
      out_valid <= valid_n;
      done      <= done_n;
      remaining <= rem_n;
    end
  end
endmodule

// File: tb/tb_encoder64to6_scan.sv
// tb_encoder64to6_scan: directed checks of the 64-to-6 scan encoder in both emission orders
module tb_encoder64to6_scan;
  logic        clk = 0, reset = 1, load = 0, out_ready = 0;
  logic [63:0] in_vec = '0;
  logic [5:0]  idx0, idx1;
  logic        val0, val1, busy0, busy1, done0, done1;
  logic [6:0]  rem0, rem1;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  encoder64to6_scan #(.MSB_FIRST(1'b0)) dut0 (.clk(clk), .reset(reset), .load(load), .in_vec(in_vec),
    .out_idx(idx0), .out_valid(val0), .out_ready(out_ready), .busy(busy0), .done(done0), .remaining(rem0));
  encoder64to6_scan #(.MSB_FIRST(1'b1)) dut1 (.clk(clk), .reset(reset), .load(load), .in_vec(in_vec),
    .out_idx(idx1), .out_valid(val1), .out_ready(out_ready), .busy(busy1), .done(done1), .remaining(rem1));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1; step();
    checks++; if ({idx0, val0, busy0, done0, rem0} !== 16'd0) begin failures++; $display("FAIL reset_lsb got=%h exp=0", {idx0, val0, busy0, done0, rem0}); end
    checks++; if ({idx1, val1, busy1, done1, rem1} !== 16'd0) begin failures++; $display("FAIL reset_msb got=%h exp=0", {idx1, val1, busy1, done1, rem1}); end
    reset = 0; step();
  endtask

  task automatic test_single();
    in_vec = 64'h1; load = 1; out_ready = 1; step(); load = 0;
    checks++; if ({val0, idx0, rem0, busy0, done0} !== {1'b1, 6'd0, 7'd1, 1'b1, 1'b0}) begin failures++; $display("FAIL single_beat got v=%b i=%0d r=%0d b=%b d=%b exp v=1 i=0 r=1 b=1 d=0", val0, idx0, rem0, busy0, done0); end
    step();
    checks++; if ({val0, rem0, busy0, done0} !== {1'b0, 7'd0, 1'b0, 1'b1}) begin failures++; $display("FAIL single_drain got v=%b r=%0d b=%b d=%b exp v=0 r=0 b=0 d=1", val0, rem0, busy0, done0); end
    step();
    checks++; if (done0 !== 1'b0) begin failures++; $display("FAIL single_done_pulse got=%b exp=0", done0); end
  endtask

  task automatic test_three();
    logic [5:0] exp_idx [3];
    exp_idx = '{6'd0, 6'd7, 6'd63};
    in_vec = 64'h8000_0000_0000_0081; load = 1; out_ready = 1; step(); load = 0;
    for (int k = 0; k < 3; k++) begin
      checks++; if ({val0, idx0, rem0} !== {1'b1, exp_idx[k], 7'(3 - k)}) begin failures++; $display("FAIL three_beat%0d got v=%b i=%0d r=%0d exp v=1 i=%0d r=%0d", k, val0, idx0, rem0, exp_idx[k], 3 - k); end
      checks++; if (done0 !== 1'b0) begin failures++; $display("FAIL three_early_done%0d got=%b exp=0", k, done0); end
      step();
    end
    checks++; if ({val0, done0, idx0} !== {1'b0, 1'b1, 6'd63}) begin failures++; $display("FAIL three_done got v=%b d=%b i=%0d exp v=0 d=1 i=63", val0, done0, idx0); end
  endtask

  task automatic test_stall();
    in_vec = 64'd1 << 40; load = 1; out_ready = 0; step(); load = 0;
    for (int k = 0; k < 3; k++) begin
      checks++; if ({val0, idx0, busy0, rem0} !== {1'b1, 6'd40, 1'b1, 7'd1}) begin failures++; $display("FAIL stall_hold%0d got v=%b i=%0d b=%b r=%0d exp v=1 i=40 b=1 r=1", k, val0, idx0, busy0, rem0); end
      if (k < 2) step();
    end
    out_ready = 1; step();
    checks++; if ({val0, done0, idx0, rem0} !== {1'b0, 1'b1, 6'd40, 7'd0}) begin failures++; $display("FAIL stall_accept got v=%b d=%b i=%0d r=%0d exp v=0 d=1 i=40 r=0", val0, done0, idx0, rem0); end
  endtask

  task automatic test_zero();
    in_vec = '0; load = 1; step(); load = 0;
    checks++; if ({val0, busy0, done0} !== 3'b001) begin failures++; $display("FAIL zero_done got v=%b b=%b d=%b exp v=0 b=0 d=1", val0, busy0, done0); end
    step();
    checks++; if ({val0, busy0, done0} !== 3'b000) begin failures++; $display("FAIL zero_after got v=%b b=%b d=%b exp 000", val0, busy0, done0); end
  endtask

  task automatic test_load_ignored();
    in_vec = 64'h5; load = 1; out_ready = 1; step();
    checks++; if ({val0, idx0, rem0} !== {1'b1, 6'd0, 7'd2}) begin failures++; $display("FAIL ign_first got v=%b i=%0d r=%0d exp v=1 i=0 r=2", val0, idx0, rem0); end
    in_vec = 64'hFFFF; step(); load = 0;
    checks++; if ({val0, idx0, rem0} !== {1'b1, 6'd2, 7'd1}) begin failures++; $display("FAIL ign_second got v=%b i=%0d r=%0d exp v=1 i=2 r=1", val0, idx0, rem0); end
    step();
    checks++; if ({val0, done0, busy0} !== 3'b010) begin failures++; $display("FAIL ign_done got v=%b d=%b b=%b exp v=0 d=1 b=0", val0, done0, busy0); end
    step();
    checks++; if ({val0, busy0, rem0} !== 9'd0) begin failures++; $display("FAIL ign_quiet got v=%b b=%b r=%0d exp 0", val0, busy0, rem0); end
  endtask

  task automatic test_reset_mid();
    in_vec = 64'hF0; load = 1; out_ready = 0; step(); load = 0;
    checks++; if ({val0, idx0, rem0} !== {1'b1, 6'd4, 7'd4}) begin failures++; $display("FAIL rmid_start got v=%b i=%0d r=%0d exp v=1 i=4 r=4", val0, idx0, rem0); end
    out_ready = 1; reset = 1; step(); reset = 0;
    checks++; if ({idx0, val0, busy0, done0, rem0} !== 16'd0) begin failures++; $display("FAIL rmid_clear got=%h exp=0", {idx0, val0, busy0, done0, rem0}); end
    for (int k = 0; k < 3; k++) begin
      step();
      checks++; if ({val0, done0, busy0} !== 3'b000) begin failures++; $display("FAIL rmid_quiet%0d got v=%b d=%b b=%b exp 000", k, val0, done0, busy0); end
    end
  endtask

  task automatic test_back_to_back();
    in_vec = 64'h1; load = 1; out_ready = 1; step(); load = 0;
    step();
    checks++; if ({done0, busy0} !== 2'b10) begin failures++; $display("FAIL b2b_drain got d=%b b=%b exp d=1 b=0", done0, busy0); end
    in_vec = 64'h2; load = 1; step(); load = 0;
    checks++; if ({val0, idx0, done0, rem0} !== {1'b1, 6'd1, 1'b0, 7'd1}) begin failures++; $display("FAIL b2b_reload got v=%b i=%0d d=%b r=%0d exp v=1 i=1 d=0 r=1", val0, idx0, done0, rem0); end
    step();
    checks++; if ({val0, done0} !== 2'b01) begin failures++; $display("FAIL b2b_done got v=%b d=%b exp v=0 d=1", val0, done0); end
  endtask

  task automatic test_msb_all_ones();
    logic [63:0] acc0, acc1;
    acc0 = '0; acc1 = '0;
    reset = 1; step(); reset = 0; step();
    in_vec = '1; load = 1; out_ready = 1; step(); load = 0;
    checks++; if ({rem0, rem1} !== {7'd64, 7'd64}) begin failures++; $display("FAIL all_rem got lsb=%0d msb=%0d exp 64", rem0, rem1); end
    for (int k = 0; k < 64; k++) begin
      checks++; if ({val1, idx1} !== {1'b1, 6'(63 - k)}) begin failures++; $display("FAIL msb_beat%0d got v=%b i=%0d exp v=1 i=%0d", k, val1, idx1, 63 - k); end
      checks++; if ({val0, idx0} !== {1'b1, 6'(k)}) begin failures++; $display("FAIL lsb_beat%0d got v=%b i=%0d exp v=1 i=%0d", k, val0, idx0, k); end
      if (val1) acc1 |= 64'd1 << idx1;
      if (val0) acc0 |= 64'd1 << idx0;
      step();
    end
    checks++; if (acc1 !== 64'hFFFF_FFFF_FFFF_FFFF) begin failures++; $display("FAIL msb_roundtrip got=%h exp=ffffffffffffffff", acc1); end
    checks++; if (acc0 !== 64'hFFFF_FFFF_FFFF_FFFF) begin failures++; $display("FAIL lsb_roundtrip got=%h exp=ffffffffffffffff", acc0); end
    checks++; if ({done1, val1, busy1, rem1} !== {1'b1, 1'b0, 1'b0, 7'd0}) begin failures++; $display("FAIL msb_done got d=%b v=%b b=%b r=%0d exp d=1 v=0 b=0 r=0", done1, val1, busy1, rem1); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_three();
    test_stall();
    test_zero();
    test_load_ignored();
    test_reset_mid();
    test_back_to_back();
    test_msb_all_ones();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
